// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// default vectors and the instruction/address width.
package fetch_sequencer_pkg;

   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] EXC_VECTOR_DEF   = 32'h0000_0080;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_adder.sv
// Plain modulo-2^W adder; any carry out of the top bit is discarded.
module Adder #(
   parameter int W = 32
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] sum_o
);

   assign sum_o = a_i + b_i;

endmodule

// File: rtl/fetch_sequencer_next_pc_select.sv
// Next-PC priority mux (exception > jump > branch > sequential) with a
// misalignment check on jump/branch targets.
module next_pc_select
   import fetch_sequencer_pkg::*;
#(
   parameter logic [INSTR_W-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic [INSTR_W-1:0] instr_pc_i,
   input  logic               exception_i,
   input  logic               jump_i,
   input  logic [INSTR_W-1:0] jump_target_i,
   input  logic               branch_taken_i,
   input  logic [INSTR_W-1:0] branch_offset_i,
   output logic [INSTR_W-1:0] next_pc_o,
   output logic               misaligned_o
);

   logic [INSTR_W-1:0] seqPc;
   logic [INSTR_W-1:0] branchPc;

   Adder #(.W(INSTR_W)) u_seq_adder (
      .a_i   (instr_pc_i),
      .b_i   (32'd4),
      .sum_o (seqPc)
   );

   Adder #(.W(INSTR_W)) u_branch_adder (
      .a_i   (seqPc),
      .b_i   (branch_offset_i),
      .sum_o (branchPc)
   );

   // A misaligned redirect is turned into a trap to the exception vector.
   always_comb begin
      next_pc_o    = seqPc;
      misaligned_o = 1'b0;
      if (exception_i) begin
         next_pc_o = EXC_VECTOR;
      end else if (jump_i) begin
         if (jump_target_i[1:0] != 2'b00) begin
            next_pc_o    = EXC_VECTOR;
            misaligned_o = 1'b1;
         end else begin
            next_pc_o = jump_target_i;
         end
      end else if (branch_taken_i) begin
         if (branchPc[1:0] != 2'b00) begin
            next_pc_o    = EXC_VECTOR;
            misaligned_o = 1'b1;
         end else begin
            next_pc_o = branchPc;
         end
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, runs the imem request/ready
// handshake and issues one instruction at a time to decode.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [INSTR_W-1:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               stall_i,
   input  logic               branch_taken_i,
   input  logic [INSTR_W-1:0] branch_offset_i,
   input  logic               jump_i,
   input  logic [INSTR_W-1:0] jump_target_i,
   input  logic               exception_i,
   output logic               imem_req_o,
   output logic [INSTR_W-1:0] imem_addr_o,
   input  logic               imem_ready_i,
   input  logic [INSTR_W-1:0] imem_rdata_i,
   output logic               instr_valid_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [INSTR_W-1:0] instr_pc_o,
   output logic               misaligned_o
);

   fetch_state_e       state_q, state_d;
   logic [INSTR_W-1:0] pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [INSTR_W-1:0] instr_pc_q, instr_pc_d;
   logic               abort_q, abort_d;

   logic               consume;
   logic [INSTR_W-1:0] nextPc;
   logic               selMisaligned;

   next_pc_select #(.EXC_VECTOR(EXC_VECTOR)) u_next_pc (
      .instr_pc_i      (instr_pc_q),
      .exception_i     (exception_i),
      .jump_i          (jump_i),
      .jump_target_i   (jump_target_i),
      .branch_taken_i  (branch_taken_i),
      .branch_offset_i (branch_offset_i),
      .next_pc_o       (nextPc),
      .misaligned_o    (selMisaligned)
   );

   assign consume = (state_q == S_ISSUE) && !stall_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_VECTOR;
         instr_q    <= '0;
         instr_pc_q <= '0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         instr_pc_q <= instr_pc_d;
         abort_q    <= abort_d;
      end
   end

   // abort_q forces one idle request cycle after a trap cuts a fetch short.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
      abort_d    = 1'b0;
      unique case (state_q)
         S_BOOT: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (exception_i) begin
               pc_d    = EXC_VECTOR;
               abort_d = 1'b1;
            end else if (!abort_q && imem_ready_i) begin
               instr_d    = imem_rdata_i;
               instr_pc_d = pc_q;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (exception_i || !stall_i) begin
               pc_d    = nextPc;
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase
   end

   always_comb begin
      imem_req_o    = (state_q == S_FETCH) && !abort_q;
      imem_addr_o   = pc_q;
      instr_valid_o = (state_q == S_ISSUE);
      instr_o       = instr_q;
      instr_pc_o    = instr_pc_q;
      misaligned_o  = consume && selMisaligned;
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a cycle-level behavioural model checked
// every negedge, plus literal expectations for the scenarios of interest.
module tb_fetch_sequencer;

   localparam logic [31:0] RV  = 32'h0000_0000;
   localparam logic [31:0] EXC = 32'h0000_0080;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall, branchTaken, jump, exception, imemReady;
   logic [31:0] branchOffset, jumpTarget, imemRdata;
   logic        imemReq, instrValid, misaligned;
   logic [31:0] imemAddr, instr, instrPc;

   int compared   = 0;
   int mismatched = 0;
   logic misSeen;

   // Model state: booting, holding an issued instruction, or in the one-cycle
   // request gap after an aborted fetch; otherwise the model is fetching.
   logic        mBoot, mHave, mHole;
   logic [31:0] mPc, mInstr, mInstrPc;

   always #5 clk = ~clk;

   assign imemRdata = imemAddr ^ 32'hDEAD_0000;

   fetch_sequencer dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .stall_i         (stall),
      .branch_taken_i  (branchTaken),
      .branch_offset_i (branchOffset),
      .jump_i          (jump),
      .jump_target_i   (jumpTarget),
      .exception_i     (exception),
      .imem_req_o      (imemReq),
      .imem_addr_o     (imemAddr),
      .imem_ready_i    (imemReady),
      .imem_rdata_i    (imemRdata),
      .instr_valid_o   (instrValid),
      .instr_o         (instr),
      .instr_pc_o      (instrPc),
      .misaligned_o    (misaligned)
   );

   function automatic logic [31:0] rawTarget();
      if (jump)             return jumpTarget;
      else if (branchTaken) return mInstrPc + 32'd4 + branchOffset;
      else                  return mInstrPc + 32'd4;
   endfunction

   function automatic logic redirectBad();
      logic [31:0] t;
      t = rawTarget();
      return (jump || branchTaken) && (t[1:0] != 2'b00);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mBoot = 1'b1; mHave = 1'b0; mHole = 1'b0;
         mPc = RV; mInstr = '0; mInstrPc = '0;
      end else if (mBoot) begin
         mBoot = 1'b0;
      end else if (mHave) begin
         if (exception || !stall) begin
            mPc   = (exception || redirectBad()) ? EXC : rawTarget();
            mHave = 1'b0;
         end
      end else if (exception) begin
         mPc   = EXC;
         mHole = 1'b1;
      end else if (mHole) begin
         mHole = 1'b0;
      end else if (imemReady) begin
         mInstr   = imemRdata;
         mInstrPc = mPc;
         mHave    = 1'b1;
      end
   end

   always @(negedge clk) begin
      checkOutput("m_imem_req", {31'd0, imemReq}, {31'd0, !mBoot && !mHave && !mHole});
      checkOutput("m_imem_addr", imemAddr, mPc);
      checkOutput("m_instr_valid", {31'd0, instrValid}, {31'd0, mHave});
      checkOutput("m_instr", instr, mInstr);
      checkOutput("m_instr_pc", instrPc, mInstrPc);
      checkOutput("m_misaligned", {31'd0, misaligned},
                  {31'd0, mHave && !stall && !exception && redirectBad()});
      checkOutput("m_req_and_valid", {31'd0, imemReq && instrValid}, 32'd0);
   end

   // One clock of stimulus, starting just after a rising edge.
   task automatic applyStimulus(input logic st, input logic br, input logic [31:0] off,
                                input logic jp, input logic [31:0] jt,
                                input logic ex, input logic rdy);
      stall = st; branchTaken = br; branchOffset = off;
      jump = jp; jumpTarget = jt; exception = ex; imemReady = rdy;
      #2 misSeen = misaligned;
      @(posedge clk);
      #1;
   endtask

   task automatic stepReady();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
   endtask

   initial begin
      stall = 0; branchTaken = 0; branchOffset = 0; jump = 0;
      jumpTarget = 0; exception = 0; imemReady = 0; misSeen = 0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_req", {31'd0, imemReq}, 32'd0);
      checkOutput("rst_addr", imemAddr, RV);
      checkOutput("rst_valid", {31'd0, instrValid}, 32'd0);
      checkOutput("rst_instr", instr, 32'd0);
      checkOutput("rst_misaligned", {31'd0, misaligned}, 32'd0);
      rst = 1'b0;

      // Sequential fetch, ready every cycle.
      stepReady();
      checkOutput("t1_req0", {31'd0, imemReq}, 32'd1);
      checkOutput("t1_addr0", imemAddr, 32'h0);
      stepReady();
      checkOutput("t1_valid0", {31'd0, instrValid}, 32'd1);
      checkOutput("t1_req_low", {31'd0, imemReq}, 32'd0);
      checkOutput("t1_instr0", instr, 32'hDEAD_0000);
      stepReady();
      checkOutput("t1_addr4", imemAddr, 32'h4);
      stepReady();
      stepReady();
      checkOutput("t1_addr8", imemAddr, 32'h8);
      stepReady();

      // Stall holds the issued instruction.
      repeat (3) begin
         applyStimulus(1'b1, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 1'b1);
         checkOutput("t2_valid", {31'd0, instrValid}, 32'd1);
         checkOutput("t2_pc", instrPc, 32'h8);
         checkOutput("t2_instr", instr, 32'hDEAD_0008);
         checkOutput("t2_req", {31'd0, imemReq}, 32'd0);
      end
      stepReady();
      checkOutput("t2_addrC", imemAddr, 32'hC);
      stepReady();
      stepReady();
      stepReady();
      checkOutput("t2_pc10", instrPc, 32'h10);

      // Backward branch, then jump beats branch.
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'd0, 1'b0, 1'b1);
      checkOutput("t3_branch_addr", imemAddr, 32'hC);
      stepReady();
      applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 1'b1);
      checkOutput("t3_jump_wins", imemAddr, 32'h40);
      stepReady();

      // Misaligned jump target traps.
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0102, 1'b0, 1'b1);
      checkOutput("t4_mis_pulse", {31'd0, misSeen}, 32'd1);
      checkOutput("t4_addr", imemAddr, EXC);
      checkOutput("t4_mis_gone", {31'd0, misaligned}, 32'd0);
      stepReady();

      // Exception during fetch with ready in the same cycle.
      stepReady();
      checkOutput("t5_addr84", imemAddr, 32'h84);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
      checkOutput("t5_req_gap", {31'd0, imemReq}, 32'd0);
      checkOutput("t5_gap_addr", imemAddr, EXC);
      checkOutput("t5_no_issue", {31'd0, instrValid}, 32'd0);
      stepReady();
      checkOutput("t5_req_back", {31'd0, imemReq}, 32'd1);
      checkOutput("t5_still_fetch", {31'd0, instrValid}, 32'd0);
      stepReady();
      checkOutput("t5_issue_pc", instrPc, EXC);
      checkOutput("t5_issue_instr", instr, 32'hDEAD_0080);

      // Exception while stalled discards the instruction.
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
      checkOutput("t5s_valid", {31'd0, instrValid}, 32'd0);
      checkOutput("t5s_addr", imemAddr, EXC);
      stepReady();

      // Wrap-around of the sequential PC.
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
      checkOutput("t6_top_addr", imemAddr, 32'hFFFF_FFFC);
      stepReady();
      stepReady();
      checkOutput("t6_wrap_addr", imemAddr, 32'h0);
      stepReady();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      checkOutput("t6_wait_addr", imemAddr, 32'h4);
      checkOutput("t6_wait_req", {31'd0, imemReq}, 32'd1);

      // Reset in the middle of a pending fetch.
      rst = 1'b1;
      #1;
      checkOutput("t6_rst_req", {31'd0, imemReq}, 32'd0);
      checkOutput("t6_rst_addr", imemAddr, RV);
      checkOutput("t6_rst_pc", instrPc, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
      checkOutput("t6_boot_exc_ignored", imemAddr, RV);
      checkOutput("t6_refetch_req", {31'd0, imemReq}, 32'd1);
      stepReady();
      checkOutput("t6_refetch_valid", {31'd0, instrValid}, 32'd1);
      checkOutput("t6_refetch_instr", instr, 32'hDEAD_0000);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
